// File: rtl/channel_to_pixel.sv
// channel_to_pixel: maps a channel number to its vertical screen placement.
// A small layout engine rebuilds a per-channel table (first row, visible
// index, visibility) whenever channel_enable changes. Lookups are answered
// one cycle after acceptance. A common height is shared by all visible channels.
// Optional feature: define CHAN_ROW_END_EN to add the resp_row_end output.
module channel_to_pixel #(
  parameter int MAX_CHAN_COUNT = 10,
  parameter int OFFSET         = 0,
  localparam int VGA_VER_RES   = 480,
  localparam int ROW_W         = $clog2(VGA_VER_RES),
  localparam int CH_W          = (MAX_CHAN_COUNT > 1) ? $clog2(MAX_CHAN_COUNT) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MAX_CHAN_COUNT-1:0] channel_enable,
  input  logic                      query_valid,
  input  logic [CH_W-1:0]           query_channel,
  output logic                      query_ready,
  output logic                      resp_valid,
  output logic                      resp_is_visible,
  output logic [ROW_W-1:0]          resp_row_start,
  output logic [ROW_W-1:0]          resp_height,
  output logic [CH_W-1:0]           resp_visible_index,
`ifdef CHAN_ROW_END_EN
  output logic [ROW_W-1:0]          resp_row_end,
`endif
  output logic [CH_W:0]             channel_count
);

  localparam int PROD_W = ROW_W + 11;
  localparam logic [PROD_W-1:0] SPAN = PROD_W'(VGA_VER_RES - OFFSET);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(MAX_CHAN_COUNT - 1);

  typedef enum logic [2:0] {
    LOAD,
    COUNT,
    SCALE,
    WALK,
    READY
  } state_t;

  state_t                    state;
  logic [MAX_CHAN_COUNT-1:0] en_snap;
  logic [ROW_W-1:0]          height;
  logic [CH_W-1:0]           walk_k;
  logic [ROW_W-1:0]          acc;
  logic [CH_W-1:0]           vis_n;
  logic [ROW_W-1:0]          tab_start [MAX_CHAN_COUNT];
  logic [CH_W-1:0]           tab_idx   [MAX_CHAN_COUNT];
  logic [MAX_CHAN_COUNT-1:0] tab_vis;
  logic [PROD_W-1:0]         scaled;

  // Reciprocal of the channel count in 10-bit fixed point (1024 = 1.0).
  function automatic logic [10:0] recip(input logic [CH_W:0] cnt);
    case (cnt)
      1:       recip = 11'd1024;
      2:       recip = 11'd512;
      3:       recip = 11'd341;
      4:       recip = 11'd256;
      5:       recip = 11'd204;
      6:       recip = 11'd170;
      7:       recip = 11'd146;
      8:       recip = 11'd128;
      9:       recip = 11'd113;
      10:      recip = 11'd102;
      default: recip = 11'd0;
    endcase
  endfunction

  // Number of set bits in the enable snapshot.
  function automatic logic [CH_W:0] popcount(input logic [MAX_CHAN_COUNT-1:0] v);
    popcount = '0;
    for (int i = 0; i < MAX_CHAN_COUNT; i++)
      popcount = popcount + (CH_W+1)'(v[i]);
  endfunction

  // Full-width product so the fraction is dropped only by the final shift.
  assign scaled = (SPAN * PROD_W'(recip(channel_count))) >> 10;

  // Layout engine: snapshot, count, scale, then walk one channel per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD;
      en_snap       <= '0;
      channel_count <= '0;
      height        <= '0;
      walk_k        <= '0;
      acc           <= '0;
      vis_n         <= '0;
      query_ready   <= 1'b0;
      tab_vis       <= '0;
      for (int i = 0; i < MAX_CHAN_COUNT; i++) begin
        tab_start[i] <= '0;
        tab_idx[i]   <= '0;
      end
    end else if (state != LOAD && channel_enable != en_snap) begin
      state       <= LOAD;
      query_ready <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          en_snap     <= channel_enable;
          query_ready <= 1'b0;
          state       <= COUNT;
        end
        COUNT: begin
          channel_count <= popcount(en_snap);
          state         <= SCALE;
        end
        SCALE: begin
          height <= scaled[ROW_W-1:0];
          walk_k <= '0;
          acc    <= ROW_W'(OFFSET);
          vis_n  <= '0;
          state  <= WALK;
        end
        WALK: begin
          if (en_snap[walk_k]) begin
            tab_start[walk_k] <= acc;
            tab_vis[walk_k]   <= 1'b1;
            tab_idx[walk_k]   <= vis_n;
            acc               <= acc + height;
            vis_n             <= vis_n + 1'b1;
          end else begin
            tab_start[walk_k] <= '0;
            tab_vis[walk_k]   <= 1'b0;
            tab_idx[walk_k]   <= '0;
          end
          if (walk_k == LAST_CH) begin
            state       <= READY;
            query_ready <= 1'b1;
          end else begin
            walk_k <= walk_k + 1'b1;
          end
        end
        READY: begin
          query_ready <= 1'b1;
        end
        default: begin
          state       <= LOAD;
          query_ready <= 1'b0;
        end
      endcase
    end
  end

  // Registered lookup: fields are zero unless the channel is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid         <= 1'b0;
      resp_is_visible    <= 1'b0;
      resp_row_start     <= '0;
      resp_height        <= '0;
      resp_visible_index <= '0;
`ifdef CHAN_ROW_END_EN
      resp_row_end       <= '0;
`endif
    end else begin
      resp_valid         <= query_valid & query_ready;
      resp_is_visible    <= 1'b0;
      resp_row_start     <= '0;
      resp_height        <= '0;
      resp_visible_index <= '0;
`ifdef CHAN_ROW_END_EN
      resp_row_end       <= '0;
`endif
      if (query_valid && query_ready &&
          ({1'b0, query_channel} < (CH_W+1)'(MAX_CHAN_COUNT))) begin
        if (tab_vis[query_channel]) begin
          resp_is_visible    <= 1'b1;
          resp_row_start     <= tab_start[query_channel];
          resp_height        <= height;
          resp_visible_index <= tab_idx[query_channel];
`ifdef CHAN_ROW_END_EN
          resp_row_end       <= tab_start[query_channel] + height - 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_to_pixel.sv
// tb_channel_to_pixel: directed test of channel_to_pixel at default parameters
// (10 channels, OFFSET 0, 480 rows). Define CHAN_ROW_END_EN to cover resp_row_end.
module tb_channel_to_pixel;

  logic       clk;
  logic       rst_n;
  logic [9:0] channel_enable;
  logic       query_valid;
  logic [3:0] query_channel;
  logic       query_ready;
  logic       resp_valid;
  logic       resp_is_visible;
  logic [8:0] resp_row_start;
  logic [8:0] resp_height;
  logic [3:0] resp_visible_index;
  logic [4:0] channel_count;
`ifdef CHAN_ROW_END_EN
  logic [8:0] resp_row_end;
`endif

  int tests_run;
  int tests_failed;
  int cycles;

  channel_to_pixel dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .channel_enable     (channel_enable),
    .query_valid        (query_valid),
    .query_channel      (query_channel),
    .query_ready        (query_ready),
    .resp_valid         (resp_valid),
    .resp_is_visible    (resp_is_visible),
    .resp_row_start     (resp_row_start),
    .resp_height        (resp_height),
    .resp_visible_index (resp_visible_index),
`ifdef CHAN_ROW_END_EN
    .resp_row_end       (resp_row_end),
`endif
    .channel_count      (channel_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive inputs, advance one rising edge, settle 1 ns past it.
  task automatic applyStimulus(input logic [9:0] en, input logic qv, input logic [3:0] qch);
    channel_enable = en;
    query_valid    = qv;
    query_channel  = qch;
    @(posedge clk);
    #1;
  endtask

  // Step with no query until query_ready rises; bounded at 40 cycles.
  task automatic waitReady(output int n);
    n = 0;
    while (!query_ready && n < 40) begin
      applyStimulus(channel_enable, 1'b0, 4'd0);
      n++;
    end
  endtask

  task automatic checkResp(input string tag, input logic vis, input int start,
                           input int hgt, input int idx);
    checkOutput({tag, "_valid"}, 32'(resp_valid), 32'd1);
    checkOutput({tag, "_vis"},   32'(resp_is_visible), 32'(vis));
    checkOutput({tag, "_start"}, 32'(resp_row_start), 32'(start));
    checkOutput({tag, "_height"}, 32'(resp_height), 32'(hgt));
    checkOutput({tag, "_idx"},   32'(resp_visible_index), 32'(idx));
  endtask

  // Directed sequence.
  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst_n          = 1'b0;
    channel_enable = '0;
    query_valid    = 1'b0;
    query_channel  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(query_ready), 32'd0);
    checkOutput("rst_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_count", 32'(channel_count), 32'd0);

    // Release reset between edges; ready must follow exactly 13 edges later.
    @(negedge clk);
    rst_n = 1'b1;
    waitReady(cycles);
    checkOutput("empty_latency", 32'(cycles), 32'd13);
    checkOutput("empty_count", 32'(channel_count), 32'd0);
    applyStimulus(10'h000, 1'b1, 4'd3);
    checkResp("empty_ch3", 1'b0, 0, 0, 0);
    applyStimulus(10'h000, 1'b0, 4'd0);
    checkOutput("idle_valid", 32'(resp_valid), 32'd0);

    // Three channels: height (480*341)>>10 = 159.
    applyStimulus(10'b00_0010_0101, 1'b0, 4'd0);
    checkOutput("three_drop", 32'(query_ready), 32'd0);
    waitReady(cycles);
    checkOutput("three_latency", 32'(cycles), 32'd13);
    checkOutput("three_count", 32'(channel_count), 32'd3);
    applyStimulus(channel_enable, 1'b1, 4'd0);
    checkResp("three_ch0", 1'b1, 0, 159, 0);
    applyStimulus(channel_enable, 1'b1, 4'd2);
    checkResp("three_ch2", 1'b1, 159, 159, 1);
    applyStimulus(channel_enable, 1'b1, 4'd5);
    checkResp("three_ch5", 1'b1, 318, 159, 2);
`ifdef CHAN_ROW_END_EN
    checkOutput("three_ch5_end", 32'(resp_row_end), 32'd476);
`endif
    applyStimulus(channel_enable, 1'b1, 4'd1);
    checkResp("three_ch1", 1'b0, 0, 0, 0);

    // All ten: height (480*102)>>10 = 47; back-to-back lookups.
    applyStimulus(10'h3FF, 1'b0, 4'd0);
    waitReady(cycles);
    checkOutput("all_latency", 32'(cycles), 32'd13);
    checkOutput("all_count", 32'(channel_count), 32'd10);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(10'h3FF, 1'b1, 4'(i));
      checkResp($sformatf("all_ch%0d", i), 1'b1, 47 * i, 47, i);
    end
    applyStimulus(10'h3FF, 1'b0, 4'd0);
    checkOutput("all_after_valid", 32'(resp_valid), 32'd0);

    // Out-of-range channel still gets a zeroed response.
    applyStimulus(10'h3FF, 1'b1, 4'd12);
    checkResp("oor_ch12", 1'b0, 0, 0, 0);

    // Change enables, then change again five cycles into the walk.
    applyStimulus(10'h003, 1'b0, 4'd0);
    repeat (8) applyStimulus(10'h003, 1'b0, 4'd0);
    checkOutput("abort_ready_low", 32'(query_ready), 32'd0);
    applyStimulus(10'h0F0, 1'b1, 4'd4);
    checkOutput("notready_valid", 32'(resp_valid), 32'd0);
    waitReady(cycles);
    checkOutput("abort_latency", 32'(cycles), 32'd13);
    checkOutput("abort_count", 32'(channel_count), 32'd4);
    applyStimulus(10'h0F0, 1'b1, 4'd0);
    checkResp("abort_ch0", 1'b0, 0, 0, 0);
    applyStimulus(10'h0F0, 1'b1, 4'd4);
    checkResp("abort_ch4", 1'b1, 0, 120, 0);
    applyStimulus(10'h0F0, 1'b1, 4'd7);
    checkResp("abort_ch7", 1'b1, 360, 120, 3);

    // Query coincident with an enable change answers from the old table.
    applyStimulus(10'h3FF, 1'b1, 4'd5);
    checkResp("race_ch5", 1'b1, 120, 120, 1);
    checkOutput("race_ready", 32'(query_ready), 32'd0);
    waitReady(cycles);
    checkOutput("race_latency", 32'(cycles), 32'd13);
    applyStimulus(10'h3FF, 1'b1, 4'd5);
    checkResp("race_new_ch5", 1'b1, 235, 47, 5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/channel_to_pixel.md
Name: channel_to_pixel

Overview:
- Inverse mapping of the row-to-channel decoder: given a channel number, returns that channel's vertical placement on screen.
- Outputs per channel: first pixel row, height in pixels, visible index.
- A sequential layout engine rebuilds a per-channel table whenever channel_enable changes.
- Answers lookups with 1-cycle latency; used by the trace drawer and label overlay to place per-channel graphics.

Parameters:
- MAX_CHAN_COUNT, 10, number of channels (1..10; the reciprocal table covers 10).
- OFFSET, 0, first row usable by channels; rows below OFFSET are never assigned.
- Derived (not overridable): ROW_W = $clog2(VGA_VER_RES) and CH_W = $clog2(MAX_CHAN_COUNT), with VGA_VER_RES from vga.h.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- channel_enable  input  MAX_CHAN_COUNT  per-channel enable; bit k = channel k.
- query_valid  input  1  lookup request; accepted when query_ready=1.
- query_channel  input  CH_W  channel number to look up.
- query_ready  output  1  layout table valid, lookups accepted.
- resp_valid  output  1  single-cycle pulse carrying a lookup result.
- resp_is_visible  output  1  queried channel is enabled and in range.
- resp_row_start  output  ROW_W  first row of the channel.
- resp_height  output  ROW_W  rows occupied by the channel.
- resp_visible_index  output  CH_W  position among enabled channels (0 = topmost).
- channel_count  output  CH_W+1  number of enabled channels in the current layout.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: state=LOAD; all outputs 0; table cleared. A reset mid-rebuild discards all progress.
- LOAD (1 cycle): snapshot channel_enable into en_snap; clear resp_valid; goto COUNT.
- COUNT (1 cycle): channel_count = popcount(en_snap); goto SCALE.
- SCALE (1 cycle): height = ((VGA_VER_RES-OFFSET)*RECIP[channel_count])>>10, 10-bit fraction.
  - RECIP for counts 1..10 = 1024, 512, 341, 256, 204, 170, 146, 128, 113, 102; count 0 -> 0.
  - Product width ROW_W+11 with no truncation before the shift. Goto WALK with k=0, acc=OFFSET, n=0.
- WALK (MAX_CHAN_COUNT cycles, one channel per cycle):
  - If en_snap[k]=1: start[k]=acc, vis[k]=1, idx[k]=n, then acc+=height and n++.
  - Else: start[k]=0, vis[k]=0, idx[k]=0.
  - After k=MAX_CHAN_COUNT-1, goto READY.
- READY: query_ready=1. Stays in READY until channel_enable != en_snap, then goes to LOAD next cycle.
- Rebuild latency: query_ready rises MAX_CHAN_COUNT+3 cycles after entering LOAD (13 at default).
- Change detection: channel_enable != en_snap in any state other than LOAD forces LOAD next cycle, aborting the current rebuild. Only the final stable value is used.
- Lookup handshake:
  - A query is accepted on a cycle with query_valid & query_ready.
  - The next cycle drives resp_valid=1 with the table contents; all resp_* are registered.
  - When resp_valid=0, resp_* hold 0.
  - Back-to-back queries give back-to-back responses. No stalls and no backpressure on responses.
- Query with query_channel >= MAX_CHAN_COUNT: response still issued, with resp_is_visible=0 and all other fields 0.
- Query for a disabled channel: resp_is_visible=0, start/height/index 0.
- Query accepted in the same cycle channel_enable changes: the response is issued from the old table; query_ready drops the following cycle.
- channel_count=0: all channels invisible, height 0; READY is still reached.
- Rows from OFFSET+channel_count*height to VGA_VER_RES-1 belong to no channel. The remainder is not redistributed.

Optional Feature:
- Macro CHAN_ROW_END_EN.
- Defined: extra output resp_row_end (ROW_W), registered alongside the other response fields.
  - Equals resp_row_start+resp_height-1 when resp_is_visible=1.
  - Otherwise 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release with channel_enable=0 -> query_ready=1 exactly 13 cycles later; channel_count=0; a query for channel 3 returns resp_is_visible=0 and zero fields.
- channel_enable='b100101, OFFSET=0, VGA_VER_RES=480 -> height 159, count 3. Responses:
  - ch0: start 0, idx 0.
  - ch2: start 159, idx 1.
  - ch5: start 318, idx 2.
  - ch1: invisible.
- All 10 enabled -> height 47. ch9: start 423, idx 9. Back-to-back queries ch0..ch9 -> 10 consecutive resp_valid pulses, each one cycle after its query.
- channel_enable toggled 5 cycles into WALK -> rebuild restarts in LOAD; query_ready stays 0 until 13 cycles after the last change; the table reflects only the final enable value.
- query_channel=12 (CH_W=4) while READY -> resp_valid=1, resp_is_visible=0, zero fields. Query while query_ready=0 -> no response.
- With CHAN_ROW_END_EN and enable='b100101, querying ch5 -> resp_row_end=476. Without the macro, the RTL compiles with no resp_row_end port.
